// File: rtl/wb_spram_bridge.sv
// Wishbone B4 classic slave bridging a decoded address window onto a
// single-port byte-enable SRAM with one-cycle registered read latency.
module wb_spram_bridge #(
  parameter int          ADDR_BITS = 9,
  parameter int          DATA_BITS = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [DATA_BITS/8-1:0] wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [DATA_BITS-1:0]   wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic                   wbs_err_o,
  output logic [DATA_BITS-1:0]   wbs_dat_o,
  output logic [ADDR_BITS-1:0]   ram_adr_o,
  output logic [DATA_BITS-1:0]   ram_dat_o,
  output logic                   ram_we_o,
  output logic [DATA_BITS/8-1:0] ram_sel_o,
  input  logic [DATA_BITS-1:0]   ram_dat_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_ACK  = 3'd2,
    WR_ACK  = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] dat_q, dat_d;
  logic                 req_s;
  logic                 hit_s;

  assign req_s = wbs_cyc_i & wbs_stb_i;
  assign hit_s = (wbs_adr_i[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);

  // The SRAM port sees the bus address/data directly; only the write strobe is gated.
  assign ram_adr_o = wbs_adr_i[ADDR_BITS-1:0];
  assign ram_dat_o = wbs_dat_i;
  assign ram_sel_o = wbs_sel_i;
  assign ram_we_o  = (state_q == IDLE) & req_s & wbs_we_i & hit_s;

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;

  // Next-state, read-data capture and registered pulse decode.
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          if (!hit_s) begin
            state_d = ERR;
          end else if (wbs_we_i) begin
            state_d = WR_ACK;
          end else begin
            state_d = RD_WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        // A master dropping cyc here abandons the read: no capture, no ack.
        if (wbs_cyc_i) begin
          state_d = RD_ACK;
          dat_d   = ram_dat_i;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ACK:  state_d = IDLE;
      WR_ACK:  state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == RD_ACK) || (state_d == WR_ACK);
    err_d = (state_d == ERR);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= {DATA_BITS{1'b0}};
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

endmodule

// File: doc/wb_spram_bridge.md
Name: wb_spram_bridge

Overview:
- Wishbone B4 classic slave that fronts the byte-enable single-port SRAM macro in the firmware payload.
- Decodes a base-address window and converts Wishbone cycles into SRAM port-A accesses.
- Absorbs the SRAM's one-cycle registered read latency and returns single-cycle ack/err pulses to the management-side master.

Parameters:
- ADDR_BITS, 9: SRAM byte-address width; window size = 2^ADDR_BITS bytes.
- DATA_BITS, 32: data width. Only 32 is supported.
- BASE_ADDR, 32'h3000_0000: window base. Bits [ADDR_BITS-1:0] must be zero.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wbs_cyc_i  input  1  bus cycle valid.
- wbs_stb_i  input  1  strobe.
- wbs_we_i  input  1  1 = write.
- wbs_sel_i  input  4  byte lane enables.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  transfer acknowledge, single-cycle pulse.
- wbs_err_o  output  1  decode error, single-cycle pulse.
- wbs_dat_o  output  32  read data.
- ram_adr_o  output  ADDR_BITS  SRAM byte address.
- ram_dat_o  output  32  SRAM write data.
- ram_we_o  output  1  SRAM write enable.
- ram_sel_o  output  4  SRAM byte enables.
- ram_dat_i  input  32  SRAM read data; valid one clock after the address is sampled.

Behaviour:
- Request: req = wbs_cyc_i & wbs_stb_i.
- Address hit: hit = (wbs_adr_i[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]). Bits [1:0] are ignored.
- Combinational passthrough:
  - ram_adr_o = wbs_adr_i[ADDR_BITS-1:0]
  - ram_dat_o = wbs_dat_i
  - ram_sel_o = wbs_sel_i
- Write enable: ram_we_o = (state==IDLE) & req & wbs_we_i & hit. It is never asserted in any other state.
- FSM states: IDLE, RD_WAIT, RD_ACK, WR_ACK, ERR. Reset state is IDLE.
- IDLE transitions:
  - req & hit & we -> WR_ACK. The SRAM write commits on this edge.
  - req & hit & !we -> RD_WAIT. The SRAM samples the address on this edge.
  - req & !hit -> ERR. No SRAM write occurs.
  - No req -> stay in IDLE.
- RD_WAIT:
  - Capture ram_dat_i into wbs_dat_o, then go to RD_ACK.
  - If wbs_cyc_i is low in this cycle: go to IDLE, do not update wbs_dat_o, issue no ack (abort).
- RD_ACK: wbs_ack_o=1 for exactly one cycle, then IDLE.
- WR_ACK: wbs_ack_o=1 for exactly one cycle, then IDLE.
- ERR: wbs_err_o=1 for exactly one cycle, then IDLE.
- Output registering: wbs_ack_o and wbs_err_o are registered outputs decoded from the next state. They are never high simultaneously.
- Latency, from the edge req is sampled in IDLE to the ack-high cycle:
  - write: 1 cycle
  - read: 2 cycles
  - error: 1 cycle
- Back-to-back: a request is only sampled in IDLE, so the ack cycle never double-issues. Minimum spacing:
  - writes: 2 cycles
  - reads: 3 cycles
- wbs_dat_o holds the last captured read data. It is unchanged by writes and errors.
- wbs_sel_i == 4'h0 write: the SRAM is accessed with no lanes enabled, and the write is still acked.
- Abort: if wbs_cyc_i drops while in WR_ACK, RD_ACK or ERR, the pulse still fires. The master ignores it per Wishbone.
- Reset values: state=IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0. ram_we_o is 0 because it is gated by IDLE & req.
- Asynchronous reset mid-transaction returns to IDLE immediately and drops any pending ack/err.

Test Plan:
- Write then read:
  - Stimulus: write 32'hDEADBEEF to BASE_ADDR+8 with sel=4'hF, then read the same address.
  - Response: write ack 1 cycle after sample; read ack 2 cycles after sample; wbs_dat_o=32'hDEADBEEF.
- Byte lanes:
  - Stimulus: write 32'h11223344 with sel=4'hF, then write 32'hAABBCCDD with sel=4'b0101 to BASE_ADDR+4, then read it.
  - Response: read returns 32'h11BB33DD.
- Decode error:
  - Stimulus: write to 32'h2000_0000.
  - Response: wbs_err_o pulses 1 cycle after sample, ram_we_o never rises, wbs_ack_o stays 0; a subsequent read of BASE_ADDR+0 returns its prior contents.
- Read abort:
  - Stimulus: start a read, then deassert wbs_cyc_i in the RD_WAIT cycle.
  - Response: no ack, wbs_dat_o unchanged, FSM in IDLE next cycle; the next read completes normally.
- Reset mid-read:
  - Stimulus: assert reset_n=0 asynchronously during RD_WAIT.
  - Response: wbs_ack_o, wbs_err_o and wbs_dat_o go to 0 immediately; no ack after release.
- Back-to-back reads:
  - Stimulus: hold stb high across 4 reads to consecutive words preloaded with 0,1,2,3.
  - Response: exactly 4 ack pulses spaced 3 cycles apart, returning 0,1,2,3 in order.
